ctrl_decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the pipelined processor. It decodes the 5-bit opcode and immediate bit of the instruction word into the 22-bit one-hot-per-function control bus and holds the result in the OF→EX pipeline register. It applies valid/ready back-pressure, branch flush, and a programmable issue interlock for multi-cycle MUL/DIV/MOD. It replaces the purely combinational decoder and drives the EX stage directly.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode_stage_if.sv | 29 ++
 rtl/ctrl_decode_comb.sv | 53 +++++
 rtl/ctrl_decode_stage.sv | 134 +++++++++++++
 tb/tb_ctrl_decode_stage.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode map, control-bus layout and helpers for the OF->EX decode stage.
package ctrl_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned CTRL_W = 22;

    typedef logic [OPC_W-1:0]  opcode_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    // Opcode map for IR[31:27]; 5'h15..5'h1F are undefined
    localparam opcode_t OP_ADD  = 5'h00;
    localparam opcode_t OP_SUB  = 5'h01;
    localparam opcode_t OP_MUL  = 5'h02;
    localparam opcode_t OP_DIV  = 5'h03;
    localparam opcode_t OP_MOD  = 5'h04;
    localparam opcode_t OP_CMP  = 5'h05;
    localparam opcode_t OP_AND  = 5'h06;
    localparam opcode_t OP_OR   = 5'h07;
    localparam opcode_t OP_NOT  = 5'h08;
    localparam opcode_t OP_MOV  = 5'h09;
    localparam opcode_t OP_LSL  = 5'h0A;
    localparam opcode_t OP_LSR  = 5'h0B;
    localparam opcode_t OP_ASR  = 5'h0C;
    localparam opcode_t OP_NOP  = 5'h0D;
    localparam opcode_t OP_LD   = 5'h0E;
    localparam opcode_t OP_ST   = 5'h0F;
    localparam opcode_t OP_BEQ  = 5'h10;
    localparam opcode_t OP_BGT  = 5'h11;
    localparam opcode_t OP_B    = 5'h12;
    localparam opcode_t OP_CALL = 5'h13;
    localparam opcode_t OP_RET  = 5'h14;

    // Control-bus bit positions
    localparam int unsigned B_IS_ST      = 0;
    localparam int unsigned B_IS_LD      = 1;
    localparam int unsigned B_IS_BEQ     = 2;
    localparam int unsigned B_IS_BGT     = 3;
    localparam int unsigned B_IS_RET     = 4;
    localparam int unsigned B_IS_IMM     = 5;
    localparam int unsigned B_IS_WB      = 6;
    localparam int unsigned B_IS_UBRANCH = 7;
    localparam int unsigned B_IS_CALL    = 8;
    localparam int unsigned B_IS_ADD     = 9;
    localparam int unsigned B_IS_SUB     = 10;
    localparam int unsigned B_IS_CMP     = 11;
    localparam int unsigned B_IS_MUL     = 12;
    localparam int unsigned B_IS_DIV     = 13;
    localparam int unsigned B_IS_MOD     = 14;
    localparam int unsigned B_IS_LSL     = 15;
    localparam int unsigned B_IS_LSR     = 16;
    localparam int unsigned B_IS_ASR     = 17;
    localparam int unsigned B_IS_OR      = 18;
    localparam int unsigned B_IS_AND     = 19;
    localparam int unsigned B_IS_NOT     = 20;
    localparam int unsigned B_IS_MOV     = 21;

    // Opcodes that occupy the multi-cycle EX unit
    function automatic logic is_muldiv(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Upstream/downstream handshake bundle of the decode stage; master = pipeline side, slave = stage.
interface ctrl_decode_stage_if
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W = 32,
    parameter int unsigned IR_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [IR_W-1:0] in_ir;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    ctrl_t           out_ctrl;
    logic [IR_W-1:0] out_ir;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_ir, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_ir, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_ir, in_pc, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_ir, out_pc, out_illegal
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure opcode/immediate -> control-bus decode. With CTRL_ILLEGAL_TRAP_EN an illegal flag is also produced.
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  opcode_t opcode,
    input  logic    imm,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic    illegal,
`endif
    output ctrl_t   ctrl
);

    logic legal;

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        unique case (opcode)
            OP_ADD:  begin ctrl[B_IS_ADD] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_SUB:  begin ctrl[B_IS_SUB] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_MUL:  begin ctrl[B_IS_MUL] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_DIV:  begin ctrl[B_IS_DIV] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_MOD:  begin ctrl[B_IS_MOD] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_CMP:  ctrl[B_IS_CMP] = 1'b1;
            OP_AND:  begin ctrl[B_IS_AND] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_OR:   begin ctrl[B_IS_OR]  = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_NOT:  begin ctrl[B_IS_NOT] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_MOV:  begin ctrl[B_IS_MOV] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_LSL:  begin ctrl[B_IS_LSL] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_LSR:  begin ctrl[B_IS_LSR] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_ASR:  begin ctrl[B_IS_ASR] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_NOP:  ;
            // Memory ops compute their address in the adder
            OP_LD:   begin ctrl[B_IS_LD] = 1'b1; ctrl[B_IS_ADD] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_ST:   begin ctrl[B_IS_ST] = 1'b1; ctrl[B_IS_ADD] = 1'b1; end
            OP_BEQ:  ctrl[B_IS_BEQ] = 1'b1;
            OP_BGT:  ctrl[B_IS_BGT] = 1'b1;
            OP_B:    ctrl[B_IS_UBRANCH] = 1'b1;
            OP_CALL: begin ctrl[B_IS_CALL] = 1'b1; ctrl[B_IS_UBRANCH] = 1'b1; ctrl[B_IS_WB] = 1'b1; end
            OP_RET:  begin ctrl[B_IS_RET] = 1'b1; ctrl[B_IS_UBRANCH] = 1'b1; end
            default: legal = 1'b0;
        endcase
        // Undefined opcodes stay all-zero, immediate flag included
        if (legal) begin
            ctrl[B_IS_IMM] = imm;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = ~legal;
`endif

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered, handshaked instruction decode stage (OF->EX register) with MUL/DIV/MOD issue interlock.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (undefined opcodes flag out_illegal and block issue until flush).
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned IR_W       = 32,
    parameter int unsigned MULDIV_LAT = 3
) (
    input  logic                clk,
    input  logic                reset,
    ctrl_decode_stage_if.slave  bus
);

    localparam int unsigned BUSY_W = $clog2(MULDIV_LAT + 1);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MULDIV_LAT - 1);

    if (IR_W < 32) begin : g_bad_ir_w
        $error("ctrl_decode_stage: IR_W must be at least 32");
    end
    if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_bad_lat
        $error("ctrl_decode_stage: MULDIV_LAT must be in 1..15");
    end

    opcode_t           opcode;
    ctrl_t             dec_ctrl;
    logic              in_ready_c;
    logic              xfer_c;
    logic              trap_c;
    logic              dec_illegal;

    logic              out_valid_q,   out_valid_d;
    ctrl_t             out_ctrl_q,    out_ctrl_d;
    logic [IR_W-1:0]   out_ir_q,      out_ir_d;
    logic [PC_W-1:0]   out_pc_q,      out_pc_d;
    logic [BUSY_W-1:0] busy_cnt_q,    busy_cnt_d;
    logic              out_illegal_q, out_illegal_d;
    logic              trap_q,        trap_d;

    assign opcode = bus.in_ir[31:27];

    ctrl_decode_comb u_decode (
        .opcode  (opcode),
        .imm     (bus.in_ir[26]),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal (dec_illegal),
`endif
        .ctrl    (dec_ctrl)
    );

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap_c = trap_q;
`else
    assign dec_illegal = 1'b0;
    assign trap_c      = 1'b0;
`endif

    // Ready depends only on registered state and out_ready, never on in_valid
    assign in_ready_c = (~out_valid_q | bus.out_ready) & (busy_cnt_q == '0) & ~trap_c;
    assign xfer_c     = bus.in_valid & in_ready_c & ~bus.flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_ctrl_d    = out_ctrl_q;
        out_ir_d      = out_ir_q;
        out_pc_d      = out_pc_q;
        out_illegal_d = out_illegal_q;
        trap_d        = trap_q;
        busy_cnt_d    = (busy_cnt_q != '0) ? busy_cnt_q - BUSY_W'(1) : busy_cnt_q;

        if (xfer_c) begin
            out_valid_d   = 1'b1;
            out_ctrl_d    = dec_ctrl;
            out_ir_d      = bus.in_ir;
            out_pc_d      = bus.in_pc;
            out_illegal_d = dec_illegal;
            if (is_muldiv(opcode)) begin
                busy_cnt_d = BUSY_LOAD;
            end
            if (dec_illegal) begin
                trap_d = 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A taken branch squashes the held entry and any pending interlock or trap
        if (bus.flush) begin
            out_valid_d = 1'b0;
            busy_cnt_d  = '0;
            trap_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_ir_q    <= '0;
            out_pc_q    <= '0;
            busy_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ctrl_q  <= out_ctrl_d;
            out_ir_q    <= out_ir_d;
            out_pc_q    <= out_pc_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_illegal_q <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            out_illegal_q <= out_illegal_d;
            trap_q        <= trap_d;
        end
    end
    assign bus.out_illegal = out_illegal_q;
`else
    assign out_illegal_q   = 1'b0;
    assign trap_q          = 1'b0;
    assign bus.out_illegal = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign bus.out_ir    = out_ir_q;
    assign bus.out_pc    = out_pc_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: directed instruction vectors, interlock, stall, flush and reset cases.
module tb_ctrl_decode_stage;
    import ctrl_pkg::*;

    localparam int unsigned PC_W = 32;
    localparam int unsigned IR_W = 32;
    localparam int unsigned LAT  = 3;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [21:0] ctrl;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_decode_stage_if #(.PC_W(PC_W), .IR_W(IR_W)) bus ();

    ctrl_decode_stage #(.PC_W(PC_W), .IR_W(IR_W), .MULDIV_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t cur;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard push: every accepted, non-squashed instruction
    always @(negedge clk) begin
        if (!reset && bus.in_valid && bus.in_ready && !bus.flush) exp_q.push_back(cur);
    end

    // Monitor: compare whenever EX takes an entry
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got ir 0x%0h expected no entry", bus.out_ir);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_ctrl",    64'(bus.out_ctrl),    64'(mon_e.ctrl));
                check("out_ir",      64'(bus.out_ir),      64'(mon_e.ir));
                check("out_pc",      64'(bus.out_pc),      64'(mon_e.pc));
                check("out_illegal", 64'(bus.out_illegal), 64'(mon_e.ill));
            end
        end
    end

    task automatic set_cur(input logic [31:0] ir, input logic [31:0] pc,
                           input logic [21:0] ctrl, input logic ill);
        cur.ir   = ir;
        cur.pc   = pc;
        cur.ctrl = ctrl;
        cur.ill  = ill;
        bus.in_ir = ir;
        bus.in_pc = pc;
    endtask

    task automatic send(input logic [31:0] ir, input logic [31:0] pc,
                        input logic [21:0] ctrl, input logic ill);
        int w;
        set_cur(ir, pc, ctrl, ill);
        bus.in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready 0 for ir 0x%0h, required 1 within 20 cycles", ir);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ir     = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        cur           = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid",   64'(bus.out_valid),   64'd0);
        check("rst_out_ctrl",    64'(bus.out_ctrl),    64'd0);
        check("rst_out_ir",      64'(bus.out_ir),      64'd0);
        check("rst_out_pc",      64'(bus.out_pc),      64'd0);
        check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
        check("rst_in_ready",    64'(bus.in_ready),    64'd1);

        // Decode table, issued back-to-back
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        c0 = cyc;
        send(32'h0000_0000, 32'h100, 22'h000240, 1'b0); // add
        send(32'h0400_0000, 32'h104, 22'h000260, 1'b0); // add imm
        send(32'h7000_0000, 32'h108, 22'h000242, 1'b0); // ld
        send(32'h7800_0000, 32'h10C, 22'h000201, 1'b0); // st
        send(32'h9800_0000, 32'h110, 22'h0001C0, 1'b0); // call
        send(32'h2800_0000, 32'h114, 22'h000800, 1'b0); // cmp
        send(32'h9000_0000, 32'h118, 22'h000080, 1'b0); // b
        send(32'hA000_0000, 32'h11C, 22'h000090, 1'b0); // ret
        send(32'h8000_0000, 32'h120, 22'h000004, 1'b0); // beq
        send(32'h8C00_0000, 32'h124, 22'h000028, 1'b0); // bgt imm
        send(32'h5800_0000, 32'h128, 22'h010040, 1'b0); // lsr
        send(32'h4000_0000, 32'h12C, 22'h100040, 1'b0); // not
        send(32'h4C00_0000, 32'h130, 22'h200060, 1'b0); // mov imm
        check("b2b_throughput", 64'(cyc - c0), 64'd13);
        send(32'h6C00_0000, 32'h134, 22'h000020, 1'b0); // nop imm
        idle_cycle();

        // MUL interlock: ready low for exactly LAT-1 cycles
        send(32'h1000_0000, 32'h200, 22'h001040, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mul_stall_c1", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("mul_stall_c2", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("mul_release",  64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(32'h1000_0000, 32'h204, 22'h001040, 1'b0); // mul
        c0 = cyc;
        send(32'h0000_0000, 32'h208, 22'h000240, 1'b0); // add
        check("mul_add_issue", 64'(cyc - c0), 64'd3);
        send(32'h1800_0000, 32'h20C, 22'h002040, 1'b0); // div
        c0 = cyc;
        send(32'h2000_0000, 32'h210, 22'h004040, 1'b0); // mod
        check("div_mod_issue", 64'(cyc - c0), 64'd3);
        idle_cycle();
        repeat (3) idle_cycle();

        // Back-pressure: held entry is stable and input blocked
        bus.out_ready = 1'b0;
        send(32'h0800_0000, 32'h300, 22'h000440, 1'b0); // sub
        set_cur(32'h3800_0000, 32'h304, 22'h040040, 1'b0); // or
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready),  64'd0);
            check("stall_valid",    64'(bus.out_valid), 64'd1);
            check("stall_ir",       64'(bus.out_ir),    64'h0800_0000);
            check("stall_ctrl",     64'(bus.out_ctrl),  64'h000440);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        c0 = cyc;
        send(32'h3800_0000, 32'h304, 22'h040040, 1'b0); // or
        send(32'h3000_0000, 32'h308, 22'h080040, 1'b0); // and
        check("drain_rate", 64'(cyc - c0), 64'd2);
        idle_cycle();
        idle_cycle();

        // Flush in the same cycle as a MUL transfer
        set_cur(32'h1000_0000, 32'h400, 22'h001040, 1'b0);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;
        c0 = cyc;
        send(32'h0000_0000, 32'h404, 22'h000240, 1'b0);
        check("flush_no_stall", 64'(cyc - c0), 64'd1);
        idle_cycle();

        // Undefined opcode
        send(32'hA800_0000, 32'h500, 22'h000000, ILL_EXP);
        bus.in_valid = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("trap_hold", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("trap_cleared", 64'(bus.in_ready), 64'd1);
`else
        @(negedge clk);
        check("no_trap_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(32'hFC00_0000, 32'h504, 22'h000000, 1'b0);
`endif
        idle_cycle();

        // Asynchronous reset in the middle of a MUL interlock
        send(32'h1000_0000, 32'h600, 22'h001040, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_ctrl",  64'(bus.out_ctrl), 64'd0);

        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
